seq_divider: RTL and testbench

//   Parametrised multi-cycle restoring divider for the CPU datapath ALU DIV op.

---
 rtl/seq_divider_if.sv | 39 +++
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the control unit and seq_divider.
// The optional abort line exists only when SEQ_DIVIDER_ABORT_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef SEQ_DIVIDER_ABORT_EN
    logic             abort;

    modport master (
        output start, signed_op, dividend, divisor, abort,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor, abort,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (signed/unsigned) with divide-by-zero detection.
// One quotient bit is resolved per ITER cycle; results are published with a
// one-cycle done pulse and held until the next done.
// Optional feature: define SEQ_DIVIDER_ABORT_EN to add an abort input that
// drops an in-flight operation without touching the published results.
module seq_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clock,
    input  logic         clear,
    seq_divider_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] ITER  = 3'd2;
    localparam logic [2:0] FIXUP = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             signed_mode;
    logic             sign_q;
    logic             sign_r;
    logic             zero_div;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic             abort_req;
    logic             in_flight;

`ifdef SEQ_DIVIDER_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_flight = (state == SETUP) || (state == ITER) || (state == FIXUP);
    assign bus.busy  = in_flight;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_mag};
        trial_ok = ~trial[WIDTH];
    end

    // Control FSM, datapath registers and result publication
    always_ff @(posedge clock) begin
        if (clear) begin
            state           <= IDLE;
            count           <= '0;
            rem             <= '0;
            quo             <= '0;
            dvs_mag         <= '0;
            signed_mode     <= 1'b0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            zero_div        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (abort_req && in_flight) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            quo         <= bus.dividend;
                            dvs_mag     <= bus.divisor;
                            signed_mode <= bus.signed_op;
                            state       <= SETUP;
                        end
                    end
                    SETUP: begin
                        sign_q <= signed_mode & (quo[WIDTH-1] ^ dvs_mag[WIDTH-1]);
                        sign_r <= signed_mode & quo[WIDTH-1];
                        rem    <= '0;
                        count  <= '0;
                        if (dvs_mag == '0) begin
                            quo      <= '1;
                            rem      <= quo;
                            zero_div <= 1'b1;
                            state    <= DONE;
                        end else begin
                            if (signed_mode && quo[WIDTH-1]) begin
                                quo <= -quo;
                            end
                            if (signed_mode && dvs_mag[WIDTH-1]) begin
                                dvs_mag <= -dvs_mag;
                            end
                            zero_div <= 1'b0;
                            state    <= ITER;
                        end
                    end
                    ITER: begin
                        rem   <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        quo   <= {quo[WIDTH-2:0], trial_ok};
                        count <= count + 1'b1;
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        if (sign_q) begin
                            quo <= -quo;
                        end
                        if (sign_r) begin
                            rem <= -rem;
                        end
                        state <= DONE;
                    end
                    DONE: begin
                        bus.done        <= 1'b1;
                        bus.quotient    <= quo;
                        bus.remainder   <= rem;
                        bus.div_by_zero <= zero_div;
                        state           <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases, randomized
// operands against an arithmetic reference model, clear and optional abort
// (SEQ_DIVIDER_ABORT_EN) scenarios.
module tb_seq_divider;
    localparam int WIDTH = 32;

    logic clock;
    logic clear;
    int   checks;
    int   fails;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // 20 ns free-running clock
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference divide computed from the arithmetic rules, not the datapath
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic [31:0] z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        z  = 0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launches one divide and checks latency, results and the done pulse shape
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  input logic [31:0] exp_q, input logic [31:0] exp_r,
                                  input logic [31:0] exp_z, input int exp_lat,
                                  input bit poke, input string tag);
        int n;
        bus.start     = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        tick();
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.signed_op = 1'($urandom_range(0, 1));
        check_output({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
            if (poke && n == 10) begin
                bus.start     = 1'b1;
                bus.dividend  = $urandom;
                bus.divisor   = $urandom_range(1, 100);
                bus.signed_op = 1'($urandom_range(0, 1));
            end
            if (poke && n == 11) begin
                bus.start = 1'b0;
            end
        end while (!bus.done && n < 100);
        check_output({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_output({tag, "_quotient"}, bus.quotient, exp_q);
        check_output({tag, "_remainder"}, bus.remainder, exp_r);
        check_output({tag, "_dz"}, 32'(bus.div_by_zero), exp_z);
        tick();
        check_output({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_output({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    // Waits a number of cycles and reports how many done pulses appeared
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done) pulses++;
        end
    endtask

    // Main test sequence
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] z;
        bit          s;
        int          pulses;
        int          kind;

        checks        = 0;
        fails         = 0;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef SEQ_DIVIDER_ABORT_EN
        bus.abort     = 1'b0;
`endif
        repeat (3) tick();
        clear = 1'b0;
        tick();
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
        check_output("reset_quotient", bus.quotient, 32'd0);
        check_output("reset_remainder", bus.remainder, 32'd0);
        check_output("reset_dz", 32'(bus.div_by_zero), 32'd0);

        $display("[TB] directed cases");
        apply_stimulus(32'h14, 32'h12, 1'b0, 32'h1, 32'h2, 0, 35, 1'b0, "u_14_12");
        apply_stimulus(32'h12, 32'h14, 1'b0, 32'h0, 32'h12, 0, 35, 1'b0, "u_12_14");
        apply_stimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 35, 1'b0, "u_max_1");
        apply_stimulus(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 35, 1'b0, "s_m7_2");
        apply_stimulus(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'h1, 0, 35, 1'b0, "s_7_m2");
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 0, 35, 1'b0,
                       "s_ovf");
        apply_stimulus(32'h18, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h18, 1, 2, 1'b0, "dz_18");
        apply_stimulus(32'h14, 32'h12, 1'b0, 32'h1, 32'h2, 0, 35, 1'b0, "dz_cleared");
        apply_stimulus(32'h64, 32'h7, 1'b0, 32'hE, 32'h2, 0, 35, 1'b1, "start_ignored");

        $display("[TB] clear mid-operation");
        bus.start    = 1'b1;
        bus.dividend = 32'h64;
        bus.divisor  = 32'h7;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_output("clear_busy", 32'(bus.busy), 32'd0);
        check_output("clear_done", 32'(bus.done), 32'd0);
        check_output("clear_quotient", bus.quotient, 32'd0);
        check_output("clear_remainder", bus.remainder, 32'd0);
        check_output("clear_dz", 32'(bus.div_by_zero), 32'd0);
        count_done(50, pulses);
        check_output("clear_no_done", 32'(pulses), 32'd0);

        $display("[TB] randomized cases");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom >> $urandom_range(0, 31);
            if (kind == 0) begin
                b = 0;
            end else if (kind == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
                s = 1'b1;
            end else if (kind == 2) begin
                a = $urandom_range(0, 50) - 25;
                b = $urandom_range(1, 9);
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            ref_div(a, b, s, q, r, z);
            apply_stimulus(a, b, s, q, r, z, (b == 0) ? 2 : 35, 1'b0, "rand");
        end

`ifdef SEQ_DIVIDER_ABORT_EN
        $display("[TB] abort mid-operation");
        apply_stimulus(32'h14, 32'h12, 1'b0, 32'h1, 32'h2, 0, 35, 1'b0, "pre_abort");
        bus.start     = 1'b1;
        bus.dividend  = 32'h64;
        bus.divisor   = 32'h7;
        bus.signed_op = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        count_done(50, pulses);
        check_output("abort_no_done", 32'(pulses), 32'd0);
        check_output("abort_quotient", bus.quotient, 32'h1);
        check_output("abort_remainder", bus.remainder, 32'h2);
        check_output("abort_dz", 32'(bus.div_by_zero), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
